fft16_frame_ctrl: RTL and testbench

FFT16_FRAME_CTRL -- requirements
Module: fft16_frame_ctrl

---
 rtl/fft_pkg.sv | 37 +++
 rtl/fft_frame_buf.sv | 36 +++
 rtl/fft16_frame_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_fft16_frame_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the 16-point FFT frame controller.
package fft_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_POW        = 4;
  localparam int unsigned N              = 2 ** DEF_POW;
  localparam int unsigned FRAME_W        = DEF_DATA_WIDTH + 8;
  localparam int unsigned RES_W          = FRAME_W + DEF_POW;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCalc,
    StUnload
  } fft_state_e;

  // Width of a frame-buffer entry: input plus 8 fractional guard bits.
  function automatic int unsigned frame_w(input int unsigned data_width);
    return data_width + 8;
  endfunction

  // Width of a butterfly-chain result: one bit of growth per stage.
  function automatic int unsigned res_w(input int unsigned data_width, input int unsigned pow);
    return data_width + 8 + pow;
  endfunction

  // Reverse the low 'pow' bits of k.
  function automatic logic [31:0] bitrev(input logic [31:0] k, input int unsigned pow);
    logic [31:0] r;
    r = '0;
    for (int unsigned b = 0; b < 32; b++) begin
      if (b < pow) r[pow - 1 - b] = k[b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// N-entry complex register array with single write port and full parallel read.
module fft_frame_buf #(
  parameter int unsigned Width = 24,
  parameter int unsigned Depth = 16,
  parameter int unsigned IdxW  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic [IdxW-1:0]         idx_i,
  input  logic signed [Width-1:0] wr_r_i,
  input  logic signed [Width-1:0] wr_i_i,
  output logic signed [Width-1:0] rd_r_o [Depth],
  output logic signed [Width-1:0] rd_i_o [Depth]
);

  logic signed [Width-1:0] mem_r_q [Depth];
  logic signed [Width-1:0] mem_i_q [Depth];

  // Storage: cleared on reset, one entry written per enabled cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < Depth; k++) begin
        mem_r_q[k] <= '0;
        mem_i_q[k] <= '0;
      end
    end else if (we_i) begin
      mem_r_q[idx_i] <= wr_r_i;
      mem_i_q[idx_i] <= wr_i_i;
    end
  end

  assign rd_r_o = mem_r_q;
  assign rd_i_o = mem_i_q;

endmodule

// File: rtl/fft16_frame_ctrl.sv
// Frame controller around a combinational FFT butterfly chain: collects one frame of
// samples, holds it steady for a multicycle settle window, captures the results and
// streams them out in natural order.
module fft16_frame_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned POW         = DEF_POW,
  parameter int unsigned CALC_CYCLES = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             sink_valid,
  output logic                             sink_ready,
  input  logic                             sink_sop,
  input  logic signed [DATA_WIDTH-1:0]     sink_r,
  input  logic signed [DATA_WIDTH-1:0]     sink_i,
  output logic signed [DATA_WIDTH+7:0]     fft_r [2**POW],
  output logic signed [DATA_WIDTH+7:0]     fft_i [2**POW],
  input  logic signed [DATA_WIDTH+POW+7:0] res_r [2**POW],
  input  logic signed [DATA_WIDTH+POW+7:0] res_i [2**POW],
  output logic                             source_valid,
  input  logic                             source_ready,
  output logic                             source_sop,
  output logic                             source_eop,
  output logic signed [DATA_WIDTH+POW+7:0] source_r,
  output logic signed [DATA_WIDTH+POW+7:0] source_i,
  output logic                             busy,
  output logic                             err
);

  localparam int unsigned Npts   = 2 ** POW;
  localparam int unsigned FrameW = frame_w(DATA_WIDTH);
  localparam int unsigned ResW   = res_w(DATA_WIDTH, POW);
  localparam int unsigned CntW   = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

  fft_state_e              state_q;
  logic [POW-1:0]          wr_idx_q;
  logic [POW-1:0]          out_k_q;
  logic [POW-1:0]          rev_k;
  logic [CntW-1:0]         calc_cnt_q;
  logic signed [ResW-1:0]  res_buf_r_q [Npts];
  logic signed [ResW-1:0]  res_buf_i_q [Npts];
  logic                    src_valid_q, src_sop_q, src_eop_q, err_q;
  logic signed [ResW-1:0]  src_r_q, src_i_q;

  logic                    accept;
  logic                    calc_done;
  logic                    buf_we;
  logic [POW-1:0]          buf_idx;
  logic signed [FrameW-1:0] wr_r, wr_i;

  assign sink_ready = (state_q == StIdle) || (state_q == StLoad);
  assign accept     = sink_valid && sink_ready;
  assign calc_done  = (state_q == StCalc) && (calc_cnt_q == CntW'(CALC_CYCLES - 1));
  assign rev_k      = POW'(bitrev(32'(out_k_q), POW));

  // Frame-buffer write decode; a start-of-packet always lands at index 0.
  always_comb begin
    buf_we  = 1'b0;
    buf_idx = wr_idx_q;
    wr_r    = {sink_r, 8'h00};
    wr_i    = {sink_i, 8'h00};
    if (accept) begin
      unique case (state_q)
        StIdle: begin
          buf_we  = sink_sop;
          buf_idx = '0;
        end
        StLoad: begin
          buf_we  = 1'b1;
          buf_idx = sink_sop ? '0 : wr_idx_q;
        end
        default: ;
      endcase
    end
  end

  fft_frame_buf #(
    .Width (FrameW),
    .Depth (Npts),
    .IdxW  (POW)
  ) u_frame_buf (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .we_i   (buf_we),
    .idx_i  (buf_idx),
    .wr_r_i (wr_r),
    .wr_i_i (wr_i),
    .rd_r_o (fft_r),
    .rd_i_o (fft_i)
  );

  // Result capture at the end of the settle window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < Npts; k++) begin
        res_buf_r_q[k] <= '0;
        res_buf_i_q[k] <= '0;
      end
    end else if (calc_done) begin
      for (int k = 0; k < Npts; k++) begin
        res_buf_r_q[k] <= res_r[k];
        res_buf_i_q[k] <= res_i[k];
      end
    end
  end

  // Main FSM with counters and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_idx_q    <= '0;
      calc_cnt_q  <= '0;
      out_k_q     <= '0;
      src_valid_q <= 1'b0;
      src_sop_q   <= 1'b0;
      src_eop_q   <= 1'b0;
      src_r_q     <= '0;
      src_i_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (sink_sop) begin
              state_q  <= StLoad;
              wr_idx_q <= POW'(1);
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (accept) begin
            if (sink_sop) begin
              err_q    <= 1'b1;
              wr_idx_q <= POW'(1);
            end else if (&wr_idx_q) begin
              state_q    <= StCalc;
              wr_idx_q   <= '0;
              calc_cnt_q <= '0;
            end else begin
              wr_idx_q <= wr_idx_q + POW'(1);
            end
          end
        end
        StCalc: begin
          if (calc_done) begin
            state_q    <= StUnload;
            calc_cnt_q <= '0;
            out_k_q    <= '0;
          end else begin
            calc_cnt_q <= calc_cnt_q + CntW'(1);
          end
        end
        StUnload: begin
          if (src_valid_q && source_ready && src_eop_q) begin
            state_q     <= StIdle;
            src_valid_q <= 1'b0;
            src_sop_q   <= 1'b0;
            src_eop_q   <= 1'b0;
            out_k_q     <= '0;
          end else if (!src_valid_q || source_ready) begin
            // Output register is empty or being drained: present the next bin.
            src_valid_q <= 1'b1;
            src_r_q     <= res_buf_r_q[rev_k];
            src_i_q     <= res_buf_i_q[rev_k];
            src_sop_q   <= (out_k_q == '0);
            src_eop_q   <= &out_k_q;
            out_k_q     <= out_k_q + POW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign source_valid = src_valid_q;
  assign source_sop   = src_sop_q;
  assign source_eop   = src_eop_q;
  assign source_r     = src_r_q;
  assign source_i     = src_i_q;
  assign busy         = (state_q != StIdle);
  assign err          = err_q;

endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// Scoreboard bench for fft16_frame_ctrl: expected bins are queued when a frame is sent,
// a monitor pops and compares on every output handshake and checks hold stability.
module tb_fft16_frame_ctrl;

  localparam int DW  = 16;
  localparam int POW = 4;
  localparam int N   = 16;
  localparam int FW  = 24;
  localparam int RW  = 28;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 sink_valid, sink_ready, sink_sop;
  logic signed [DW-1:0] sink_r, sink_i;
  logic signed [FW-1:0] fft_r [N];
  logic signed [FW-1:0] fft_i [N];
  logic signed [RW-1:0] res_r [N];
  logic signed [RW-1:0] res_i [N];
  logic                 source_valid, source_ready, source_sop, source_eop;
  logic signed [RW-1:0] source_r, source_i;
  logic                 busy, err;

  typedef struct {
    longint r;
    longint i;
    bit     sop;
    bit     eop;
  } bin_t;

  bin_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pops = 0;
  int   err_pulses = 0;
  int   rev_tab [N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  always #5 clk = ~clk;

  fft16_frame_ctrl #(
    .DATA_WIDTH  (DW),
    .POW         (POW),
    .CALC_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_sop     (sink_sop),
    .sink_r       (sink_r),
    .sink_i       (sink_i),
    .fft_r        (fft_r),
    .fft_i        (fft_i),
    .res_r        (res_r),
    .res_i        (res_i),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_r     (source_r),
    .source_i     (source_i),
    .busy         (busy),
    .err          (err)
  );

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Output monitor: scoreboard pops on handshake, hold checks under backpressure.
  initial begin
    bit     hold;
    longint h_r, h_i;
    bit     h_sop, h_eop;
    bin_t   e;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (err) err_pulses++;
        if (hold) begin
          chk("hold_valid", longint'(source_valid), 1);
          chk("hold_r", longint'(source_r), h_r);
          chk("hold_i", longint'(source_i), h_i);
          chk("hold_sop_eop", {source_sop, source_eop}, {h_sop, h_eop});
        end
        if (source_valid && source_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_bin", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("bin_r", longint'(source_r), e.r);
            chk("bin_i", longint'(source_i), e.i);
            chk("bin_sop", longint'(source_sop), longint'(e.sop));
            chk("bin_eop", longint'(source_eop), longint'(e.eop));
          end
          pops++;
        end
        hold  = source_valid && !source_ready;
        h_r   = longint'(source_r);
        h_i   = longint'(source_i);
        h_sop = source_sop;
        h_eop = source_eop;
      end
    end
  end

  task automatic set_res(input int off);
    for (int j = 0; j < N; j++) begin
      res_r[j] = RW'(off + j);
      res_i[j] = RW'(-(off + j) - 1);
    end
  endtask

  task automatic push_frame(input int off);
    for (int k = 0; k < N; k++) begin
      sb.push_back('{r: longint'(off + rev_tab[k]), i: longint'(-(off + rev_tab[k]) - 1),
                     sop: (k == 0), eop: (k == N - 1)});
    end
  endtask

  task automatic send(input int r, input int i, input bit sop);
    sink_valid = 1'b1;
    sink_r     = DW'(r);
    sink_i     = DW'(i);
    sink_sop   = sop;
    @(posedge clk);
    #1;
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
  endtask

  task automatic wait_idle(input bit toggle);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        done = 1'b1;
        break;
      end
      if (toggle) source_ready = !source_ready;
    end
    chk("unload_done", longint'(done), 1);
  endtask

  initial begin
    int lat;
    int e0;
    sink_valid   = 1'b0;
    sink_sop     = 1'b0;
    sink_r       = '0;
    sink_i       = '0;
    source_ready = 1'b1;
    set_res(0);

    // Reset state
    #12;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_src_valid", longint'(source_valid), 0);
    chk("rst_sink_ready", longint'(sink_ready), 1);
    chk("rst_err", longint'(err), 0);
    chk("rst_fft_r3", longint'(fft_r[3]), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Frame 1: ramp input, no backpressure, sink held active through CALC/UNLOAD
    pops = 0;
    push_frame(0);
    for (int k = 0; k < N; k++) send(k + 1, 0, (k == 0));
    e0         = err_pulses;
    sink_valid = 1'b1;
    sink_sop   = 1'b1;
    sink_r     = 16'sd77;
    sink_i     = 16'sd5;
    chk("calc_sink_ready", longint'(sink_ready), 0);
    chk("calc_busy", longint'(busy), 1);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (source_valid) begin
        lat = c;
        break;
      end
    end
    chk("latency", lat, 5);
    for (int k = 0; k < N; k++) begin
      chk("f1_fft_r", longint'(fft_r[k]), longint'((k + 1) * 256));
      chk("f1_fft_i", longint'(fft_i[k]), 0);
    end
    wait_idle(1'b0);
    chk("f1_idle_sink_ready", longint'(sink_ready), 1);
    chk("f1_fft_r0_kept", longint'(fft_r[0]), 256);
    chk("f1_fft_i0_kept", longint'(fft_i[0]), 0);
    chk("f1_no_err", err_pulses - e0, 0);
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    chk("f1_pops", pops, 16);
    chk("f1_sb_empty", sb.size(), 0);

    // Frame 2: negative input, ready toggling every cycle
    set_res(100);
    pops = 0;
    push_frame(100);
    for (int k = 0; k < N; k++) send(-(k + 1), 2 * k, (k == 0));
    for (int k = 0; k < N; k++) begin
      chk("f2_fft_r", longint'(fft_r[k]), -longint'(k + 1) * 256);
      chk("f2_fft_i", longint'(fft_i[k]), longint'(k) * 512);
    end
    wait_idle(1'b1);
    source_ready = 1'b1;
    chk("f2_pops", pops, 16);
    chk("f2_sb_empty", sb.size(), 0);

    // Protocol errors: stray sample in IDLE, then sop restart mid-frame
    e0 = err_pulses;
    send(9, 9, 1'b0);
    chk("idle_err", longint'(err), 1);
    chk("idle_stays", longint'(busy), 0);
    @(posedge clk);
    #1;
    chk("idle_err_pulse", longint'(err), 0);
    chk("idle_dropped", longint'(fft_r[0]), -256);
    send(1, 0, 1'b1);
    for (int k = 1; k < 6; k++) send(k + 1, 0, 1'b0);
    send(50, 3, 1'b1);
    chk("restart_err", longint'(err), 1);
    chk("restart_busy", longint'(busy), 1);
    chk("restart_fft_r0", longint'(fft_r[0]), 50 * 256);
    chk("restart_fft_i0", longint'(fft_i[0]), 3 * 256);
    for (int k = 1; k < 15; k++) send(50 + k, 0, 1'b0);
    chk("restart_still_load", longint'(sink_ready), 1);
    send(65, 0, 1'b0);
    chk("restart_calc", longint'(sink_ready), 0);
    chk("restart_fft_r6", longint'(fft_r[6]), 56 * 256);
    chk("restart_fft_r15", longint'(fft_r[15]), 65 * 256);
    set_res(200);
    pops = 0;
    push_frame(200);
    wait_idle(1'b0);
    chk("restart_pops", pops, 16);
    chk("err_count", err_pulses - e0, 2);

    // Reset in the middle of the unload, with bin 5 presented
    set_res(300);
    pops = 0;
    push_frame(300);
    for (int k = 0; k < N; k++) send(k + 1, 0, (k == 0));
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (pops >= 5) break;
    end
    chk("unload_k5", pops, 5);
    @(posedge clk);
    #1;
    chk("k5_valid", longint'(source_valid), 1);
    chk("k5_r", longint'(source_r), 310);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", longint'(source_valid), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_sop", longint'(source_sop), 0);
    chk("mid_rst_src_r", longint'(source_r), 0);
    chk("mid_rst_fft_r0", longint'(fft_r[0]), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_sink_ready", longint'(sink_ready), 1);
    chk("post_rst_busy", longint'(busy), 0);
    chk("post_rst_valid", longint'(source_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
